// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, wait-counter
// sizing and the helper that classifies the access issued in a cycle.
package dmem_arbiter_pkg;

    localparam int DEFAULT_MAX_WAIT = 4;
    localparam int WAIT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2,
        DBG_WR = 2'd3
    } owner_e;

    // A CPU store produces no response, so it is recorded as IDLE.
    function automatic owner_e issued_owner(
        input logic dbg_gnt,
        input logic dbg_we,
        input logic cpu_go,
        input logic cpu_we
    );
        if (dbg_gnt) begin
            return dbg_we ? DBG_WR : DBG_RD;
        end
        if (cpu_go && !cpu_we) begin
            return CPU_RD;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the M-stage CPU port, the debug port and the single-port RAM.
// The arbiter takes the slave view; the surrounding pipeline/debug/RAM take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_valid;
    logic              dbg_ready;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_hold;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the M-stage CPU port and a
// debug port; debug wins when holding, when the CPU is idle, or after MAX_WAIT cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    owner_e            owner;
    owner_e            owner_nxt;

    logic              dbg_gnt;
    logic              cpu_go;
    logic              ram_we_mux;
    logic [ADDR_W-1:0] ram_addr_mux;
    logic [DATA_W-1:0] ram_wdata_mux;
    logic [DATA_W-1:0] cpu_rdata_q;

    assign dbg_gnt       = bus.dbg_valid &
                           (bus.dbg_hold | ~bus.cpu_req | (wait_cnt == WAIT_LIMIT));
    assign bus.dbg_ready = dbg_gnt;
    assign bus.cpu_stall = bus.cpu_req & (dbg_gnt | bus.dbg_hold);
    assign cpu_go        = bus.cpu_req & ~bus.cpu_stall;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        ram_we_mux    = 1'b0;
        ram_addr_mux  = bus.cpu_addr;
        ram_wdata_mux = bus.cpu_wdata;
        if (dbg_gnt) begin
            ram_we_mux    = bus.dbg_we;
            ram_addr_mux  = bus.dbg_addr;
            ram_wdata_mux = bus.dbg_wdata;
        end else if (cpu_go) begin
            ram_we_mux    = bus.cpu_we;
        end
    end

    // The write strobe is gated by reset so nothing can land while rst is low.
    assign bus.ram_we    = ram_we_mux & rst;
    assign bus.ram_addr  = ram_addr_mux;
    assign bus.ram_wdata = ram_wdata_mux;

    always_comb begin
        wait_cnt_nxt = '0;
        if (bus.dbg_valid && !dbg_gnt) begin
            wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
        owner_nxt = issued_owner(dbg_gnt, bus.dbg_we, cpu_go, bus.cpu_we);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            owner    <= IDLE;
            wait_cnt <= '0;
        end else begin
            owner    <= owner_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Load-data holding register keeps a stalled load's result stable.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this data register is reset only because its value is visible on cpu_rdata during reset.
        if (!rst) begin
            cpu_rdata_q <= '0;
        end else if (owner == CPU_RD) begin
            cpu_rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.cpu_rdata  = (owner == CPU_RD) ? bus.ram_rdata : cpu_rdata_q;
    assign bus.dbg_rvalid = (owner == DBG_RD);
    assign bus.dbg_rdata  = bus.ram_rdata;

endmodule
